// File: rtl/regfile_wb_ctrl_pkg.sv
// Shared encodings for the register-file write-back path: write-bus kinds,
// the R15 index and the issue FSM states.
package regfile_wb_ctrl_pkg;

  localparam logic [1:0] WB_NONE     = 2'b00;
  localparam logic [1:0] WB_DEST     = 2'b01;
  localparam logic [1:0] WB_DEST_R15 = 2'b10;

  localparam logic [3:0] R15_IDX = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_HOLD  = 2'd2
  } wb_state_e;

  // Only kinds 01 and 10 produce a register-file write; 00 and 11 are dropped.
  function automatic logic kind_writes(input logic [1:0] kind);
    return (kind == WB_DEST) || (kind == WB_DEST_R15);
  endfunction

endpackage

// File: rtl/regfile_wb_ctrl_fifo.sv
// Pending-write FIFO with occupancy count; exposes every slot's dest/kind and
// a validity mask so the owner can compare against all queued writes.
module wb_fifo
  import regfile_wb_ctrl_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int DW    = 16,
  parameter int AW    = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push_i,
  input  logic                          pop_i,
  input  logic [AW-1:0]                 dest_i,
  input  logic [1:0]                    kind_i,
  input  logic [DW-1:0]                 data_i,
  input  logic [DW-1:0]                 r15_i,
  output logic [AW-1:0]                 dest_o,
  output logic [1:0]                    kind_o,
  output logic [DW-1:0]                 data_o,
  output logic [DW-1:0]                 r15_o,
  output logic [$clog2(DEPTH):0]        count_o,
  output logic [DEPTH-1:0][AW-1:0]      ent_dest_o,
  output logic [DEPTH-1:0][1:0]         ent_kind_o,
  output logic [DEPTH-1:0]              ent_vld_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DEPTH-1:0][AW-1:0] dest_q;
  logic [DEPTH-1:0][1:0]    kind_q;
  logic [DEPTH-1:0][DW-1:0] data_q;
  logic [DEPTH-1:0][DW-1:0] r15_q;
  logic [PW-1:0]            wr_ptr_q;
  logic [PW-1:0]            rd_ptr_q;
  logic [CW-1:0]            count_q;
  logic                     push_ok;
  logic                     pop_ok;

  assign push_ok = push_i && (count_q != CW'(DEPTH));
  assign pop_ok  = pop_i && (count_q != '0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

  // Payload storage carries no reset: validity comes from pointers and count.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      dest_q[wr_ptr_q] <= dest_i;
      kind_q[wr_ptr_q] <= kind_i;
      data_q[wr_ptr_q] <= data_i;
      r15_q[wr_ptr_q]  <= r15_i;
    end
  end

  assign dest_o  = dest_q[rd_ptr_q];
  assign kind_o  = kind_q[rd_ptr_q];
  assign data_o  = data_q[rd_ptr_q];
  assign r15_o   = r15_q[rd_ptr_q];
  assign count_o = count_q;

  assign ent_dest_o = dest_q;
  assign ent_kind_o = kind_q;

  // A slot is live when its distance from the read pointer is below count.
  for (genvar g = 0; g < DEPTH; g++) begin : g_vld
    assign ent_vld_o[g] = ({1'b0, PW'(g) - rd_ptr_q}) < count_q;
  end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Register-file write-back controller: buffers execute results, issues one
// registered write per cycle and flags read-after-write hazards for decode.
module regfile_wb_ctrl
  import regfile_wb_ctrl_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int DW    = 16,
  parameter int AW    = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [AW-1:0]          in_dest,
  input  logic [DW-1:0]          in_data,
  input  logic [DW-1:0]          in_r15,
  input  logic [1:0]             in_kind,
  input  logic                   wb_hold,
  input  logic [AW-1:0]          chk_reg1,
  input  logic [AW-1:0]          chk_reg2,
  output logic                   hazard1,
  output logic                   hazard2,
  output logic [AW-1:0]          WriteReg,
  output logic [DW-1:0]          WriteData,
  output logic [DW-1:0]          WriteR15,
  output logic [1:0]             RegWrite,
  output logic [$clog2(DEPTH):0] count
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [AW-1:0] R15 = AW'(R15_IDX);

  wb_state_e           state_q;
  logic [1:0]          regwrite_q;
  logic [AW-1:0]       wreg_q;
  logic [DW-1:0]       wdata_q;
  logic [DW-1:0]       wr15_q;

  logic [AW-1:0]            head_dest;
  logic [1:0]               head_kind;
  logic [DW-1:0]            head_data;
  logic [DW-1:0]            head_r15;
  logic [CW-1:0]            fifo_count;
  logic [CW-1:0]            count_d;
  logic [DEPTH-1:0][AW-1:0] ent_dest;
  logic [DEPTH-1:0][1:0]    ent_kind;
  logic [DEPTH-1:0]         ent_vld;
  logic                     push;
  logic                     pop;

  assign in_ready = (fifo_count < CW'(DEPTH));
  assign push     = in_valid && in_ready && kind_writes(in_kind);
  // Registered count gates pop, so an entry pushed this edge waits one cycle.
  assign pop      = (fifo_count != '0) && !wb_hold;
  assign count_d  = fifo_count + CW'(push) - CW'(pop);
  assign count    = fifo_count;

  wb_fifo #(
    .DEPTH(DEPTH),
    .DW   (DW),
    .AW   (AW)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push_i    (push),
    .pop_i     (pop),
    .dest_i    (in_dest),
    .kind_i    (in_kind),
    .data_i    (in_data),
    .r15_i     (in_r15),
    .dest_o    (head_dest),
    .kind_o    (head_kind),
    .data_o    (head_data),
    .r15_o     (head_r15),
    .count_o   (fifo_count),
    .ent_dest_o(ent_dest),
    .ent_kind_o(ent_kind),
    .ent_vld_o (ent_vld)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      regwrite_q <= WB_NONE;
      wreg_q     <= '0;
      wdata_q    <= '0;
      wr15_q     <= '0;
    end else begin
      if (pop) begin
        regwrite_q <= head_kind;
        wreg_q     <= head_dest;
        wdata_q    <= head_data;
        wr15_q     <= head_r15;
      end else begin
        regwrite_q <= WB_NONE;
      end

      case (state_q)
        ST_IDLE: begin
          if (fifo_count != '0) state_q <= wb_hold ? ST_HOLD : ST_ISSUE;
        end
        ST_ISSUE: begin
          if (wb_hold)              state_q <= ST_HOLD;
          else if (count_d == '0)   state_q <= ST_IDLE;
        end
        ST_HOLD: begin
          if (!wb_hold) state_q <= (fifo_count != '0) ? ST_ISSUE : ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign RegWrite  = regwrite_q;
  assign WriteReg  = wreg_q;
  assign WriteData = wdata_q;
  assign WriteR15  = wr15_q;

  // Pending writes are every live FIFO slot plus the entry on the bus, whose
  // commit happens on the next edge; kind 10 also claims R15.
  always_comb begin
    hazard1 = 1'b0;
    hazard2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_vld[i]) begin
        if ((ent_dest[i] == chk_reg1) ||
            ((chk_reg1 == R15) && (ent_kind[i] == WB_DEST_R15))) hazard1 = 1'b1;
        if ((ent_dest[i] == chk_reg2) ||
            ((chk_reg2 == R15) && (ent_kind[i] == WB_DEST_R15))) hazard2 = 1'b1;
      end
    end
    if (regwrite_q != WB_NONE) begin
      if ((wreg_q == chk_reg1) ||
          ((chk_reg1 == R15) && (regwrite_q == WB_DEST_R15))) hazard1 = 1'b1;
      if ((wreg_q == chk_reg2) ||
          ((chk_reg2 == R15) && (regwrite_q == WB_DEST_R15))) hazard2 = 1'b1;
    end
  end

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Scoreboard bench for regfile_wb_ctrl: stimulus queues expected bus writes,
// a negedge monitor pops and compares every write the DUT presents.
module tb_regfile_wb_ctrl;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_dest;
  logic [15:0] in_data;
  logic [15:0] in_r15;
  logic [1:0]  in_kind;
  logic        wb_hold;
  logic [3:0]  chk_reg1;
  logic [3:0]  chk_reg2;
  logic        hazard1;
  logic        hazard2;
  logic [3:0]  WriteReg;
  logic [15:0] WriteData;
  logic [15:0] WriteR15;
  logic [1:0]  RegWrite;
  logic [2:0]  count;

  typedef struct packed {
    logic [3:0]  d;
    logic [1:0]  k;
    logic [15:0] data;
    logic [15:0] r15;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] rf [16] = '{default: 16'h0};

  regfile_wb_ctrl #(.DEPTH(4), .DW(16), .AW(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_dest  (in_dest),
    .in_data  (in_data),
    .in_r15   (in_r15),
    .in_kind  (in_kind),
    .wb_hold  (wb_hold),
    .chk_reg1 (chk_reg1),
    .chk_reg2 (chk_reg2),
    .hazard1  (hazard1),
    .hazard2  (hazard2),
    .WriteReg (WriteReg),
    .WriteData(WriteData),
    .WriteR15 (WriteR15),
    .RegWrite (RegWrite),
    .count    (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Register file fed by the write bus; commits on the edge ending a bus cycle.
  always @(posedge clk) begin
    if (rst && RegWrite != 2'b00) begin
      rf[WriteReg] <= WriteData;
      if (RegWrite == 2'b10) rf[15] <= WriteR15;
    end
  end

  always @(negedge clk) begin
    if (RegWrite != 2'b00) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_write: got reg %0h data %0h kind %0h expected none",
                 WriteReg, WriteData, RegWrite);
      end else begin
        mon_e = sb.pop_front();
        check("bus_reg", 32'(WriteReg), 32'(mon_e.d));
        check("bus_kind", 32'(RegWrite), 32'(mon_e.k));
        check("bus_data", 32'(WriteData), 32'(mon_e.data));
        if (mon_e.k == 2'b10) check("bus_r15", 32'(WriteR15), 32'(mon_e.r15));
      end
    end
  end

  task automatic push(input logic [3:0] d, input logic [15:0] dat, input logic [15:0] r,
                      input logic [1:0] k, input bit acc);
    in_valid = 1'b1;
    in_dest  = d;
    in_data  = dat;
    in_r15   = r;
    in_kind  = k;
    check("in_ready", 32'(in_ready), 32'(acc));
    if (acc && (k == 2'b01 || k == 2'b10)) sb.push_back('{d: d, k: k, data: dat, r15: r});
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    check("drain_timeout", 32'(sb.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b1; in_dest = 4'd5; in_data = 16'h5555; in_r15 = 16'h0;
    in_kind = 2'b01; wb_hold = 1'b0; chk_reg1 = 4'd1; chk_reg2 = 4'd15;

    // Reset with in_valid asserted: nothing may enqueue.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_regwrite", 32'(RegWrite), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    @(posedge clk);
    #1 rst = 1'b1; in_valid = 1'b0;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_count_rel", 32'(count), 32'd0);
    check("rst_writereg", 32'(WriteReg), 32'd0);
    check("rst_writedata", 32'(WriteData), 32'd0);
    check("rst_writer15", 32'(WriteR15), 32'd0);

    // Single write with hazard tracking on R1.
    push(4'd1, 16'hABCD, 16'h0, 2'b01, 1'b1);
    check("haz1_queued", 32'(hazard1), 32'd1);
    check("count_after_push", 32'(count), 32'd1);
    @(posedge clk); #1;
    check("haz1_on_bus", 32'(hazard1), 32'd1);
    check("bus_kind_single", 32'(RegWrite), 32'd1);
    check("count_after_pop", 32'(count), 32'd0);
    @(posedge clk); #1;
    check("haz1_cleared", 32'(hazard1), 32'd0);
    check("bus_idle_single", 32'(RegWrite), 32'd0);
    check("rf_r1", 32'(rf[1]), 32'hABCD);

    // MUL result writes R2 and R15.
    push(4'd2, 16'h1234, 16'hB45C, 2'b10, 1'b1);
    check("haz2_r15_queued", 32'(hazard2), 32'd1);
    @(posedge clk); #1;
    check("haz2_r15_bus", 32'(hazard2), 32'd1);
    @(posedge clk); #1;
    check("haz2_r15_cleared", 32'(hazard2), 32'd0);
    check("rf_r2", 32'(rf[2]), 32'h1234);
    check("rf_r15", 32'(rf[15]), 32'hB45C);

    // Kinds 00 and 11 complete the handshake but never write.
    push(4'd6, 16'h6666, 16'h0, 2'b00, 1'b1);
    push(4'd6, 16'h7777, 16'h0, 2'b11, 1'b1);
    check("dropped_count", 32'(count), 32'd0);
    repeat (2) @(posedge clk); #1;
    check("rf_r6", 32'(rf[6]), 32'h0);

    // Fill under hold: fifth push is refused.
    wb_hold = 1'b1;
    push(4'd4, 16'h1001, 16'h0, 2'b01, 1'b1);
    push(4'd5, 16'h1002, 16'h0, 2'b01, 1'b1);
    push(4'd10, 16'h1003, 16'hC0DE, 2'b10, 1'b1);
    push(4'd11, 16'h1004, 16'h0, 2'b01, 1'b1);
    check("full_count", 32'(count), 32'd4);
    push(4'd12, 16'h1005, 16'h0, 2'b01, 1'b0);
    check("full_count_after_refuse", 32'(count), 32'd4);
    check("hold_bus_idle", 32'(RegWrite), 32'd0);
    wb_hold = 1'b0;
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("burst_active", 32'(RegWrite != 2'b00), 32'd1);
    end
    @(negedge clk);
    check("burst_end_idle", 32'(RegWrite), 32'd0);
    drain();
    check("rf_r12_untouched", 32'(rf[12]), 32'd0);
    check("rf_r11", 32'(rf[11]), 32'h1004);

    // Same register twice; the second push coincides with the first pop.
    push(4'd3, 16'h0001, 16'h0, 2'b01, 1'b1);
    push(4'd3, 16'h0002, 16'h0, 2'b01, 1'b1);
    check("push_pop_count", 32'(count), 32'd1);
    drain();
    check("rf_r3_last_wins", 32'(rf[3]), 32'h0002);

    // Reset after the first of three queued writes has popped.
    wb_hold = 1'b1;
    push(4'd7, 16'h0707, 16'h0, 2'b01, 1'b1);
    push(4'd8, 16'h0808, 16'h0, 2'b01, 1'b1);
    push(4'd9, 16'h0909, 16'h0, 2'b01, 1'b1);
    check("pre_rst_count", 32'(count), 32'd3);
    wb_hold = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midrst_regwrite", 32'(RegWrite), 32'd0);
    check("midrst_count", 32'(count), 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    sb.delete();
    repeat (6) @(posedge clk); #1;
    check("midrst_count_after", 32'(count), 32'd0);
    check("rf_r8_never", 32'(rf[8]), 32'd0);
    check("rf_r9_never", 32'(rf[9]), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
